// File: rtl/uart_fifo_cfg_if.sv
// Client-side byte handshakes for uart_fifo_cfg: TX FIFO push and RX FIFO pop.
interface uart_fifo_cfg_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/uart_fifo_cfg.sv
// Full-duplex UART with runtime baud divisor, configurable character format,
// TX/RX FIFOs with valid/ready handshakes and sticky RX error flags.
module uart_fifo_cfg #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DIV_W-1:0]    baud_div,
    input  logic                rx,
    output logic                tx,
    uart_fifo_cfg_if.slave      bus,
    output logic [DEPTH_LOG2:0] tx_level,
    output logic [DEPTH_LOG2:0] rx_level,
    output logic                tx_idle,
    output logic                rx_frame_err,
    output logic                rx_parity_err,
    output logic                rx_overrun,
    input  logic                err_clear
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;
    localparam int unsigned AW    = DEPTH_LOG2;
    localparam int unsigned BW    = 3;
    localparam logic        HAS_PAR = (PARITY != 0);
    localparam logic        PAR_ODD = (PARITY == 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] tx_mem [DEPTH];
    logic [PW-1:0]        tx_wr, tx_rd;
    logic                 tx_full, tx_empty, tx_push, tx_pop;
    logic [DATA_BITS-1:0] tx_head;

    assign tx_full      = (tx_wr[PW-1] != tx_rd[PW-1]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
    assign tx_empty     = (tx_wr == tx_rd);
    assign tx_push      = bus.tx_valid && !tx_full;
    assign tx_head      = tx_mem[tx_rd[AW-1:0]];
    assign bus.tx_ready = !tx_full;
    assign tx_level     = tx_wr - tx_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr <= '0;
            tx_rd <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + PW'(1);
            if (tx_pop)  tx_rd <= tx_rd + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr[AW-1:0]] <= bus.tx_data;
    end

    // ---------------- TX FSM ----------------
    tx_state_t            tx_state;
    logic [DIV_W-1:0]     tx_cnt, tx_div;
    logic [DATA_BITS-1:0] tx_shift;
    logic [BW-1:0]        tx_bit;
    logic                 tx_par, tx_stop_n;
    logic                 tx_bit_end, tx_last_stop, tx_line;

    assign tx_bit_end   = (tx_cnt == tx_div);
    assign tx_last_stop = (STOP_BITS == 1) || tx_stop_n;
    assign tx_pop       = !tx_empty && ((tx_state == TX_IDLE) ||
                          ((tx_state == TX_STOP) && tx_bit_end && tx_last_stop));
    assign tx_idle      = tx_empty && (tx_state == TX_IDLE);

    // Line level implied by the current state; registered into tx each cycle.
    always_comb begin
        tx_line = 1'b1;
        case (tx_state)
            TX_START:  tx_line = 1'b0;
            TX_DATA:   tx_line = tx_shift[0];
            TX_PARITY: tx_line = tx_par;
            default:   tx_line = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_div    <= '0;
            tx_shift  <= '0;
            tx_bit    <= '0;
            tx_par    <= 1'b0;
            tx_stop_n <= 1'b0;
            tx        <= 1'b1;
        end else begin
            tx <= tx_line;
            if (tx_pop) begin
                tx_state <= TX_START;
                tx_cnt   <= '0;
                tx_div   <= baud_div;
                tx_shift <= tx_head;
                tx_par   <= (^tx_head) ^ PAR_ODD;
            end else if (tx_state != TX_IDLE) begin
                if (!tx_bit_end) begin
                    tx_cnt <= tx_cnt + DIV_W'(1);
                end else begin
                    tx_cnt <= '0;
                    case (tx_state)
                        TX_START: begin
                            tx_state <= TX_DATA;
                            tx_bit   <= '0;
                        end
                        TX_DATA: begin
                            tx_shift <= tx_shift >> 1;
                            if (tx_bit == BW'(DATA_BITS - 1)) begin
                                tx_state  <= HAS_PAR ? TX_PARITY : TX_STOP;
                                tx_stop_n <= 1'b0;
                            end else begin
                                tx_bit <= tx_bit + BW'(1);
                            end
                        end
                        TX_PARITY: begin
                            tx_state  <= TX_STOP;
                            tx_stop_n <= 1'b0;
                        end
                        TX_STOP: begin
                            if (tx_last_stop) tx_state  <= TX_IDLE;
                            else              tx_stop_n <= 1'b1;
                        end
                        default: tx_state <= TX_IDLE;
                    endcase
                end
            end
        end
    end

    // ---------------- RX synchroniser ----------------
    logic rx_s1, rx_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
        end
    end

    // ---------------- RX FSM ----------------
    rx_state_t            rx_state;
    logic [DIV_W-1:0]     rx_cnt, rx_div;
    logic [DATA_BITS-1:0] rx_shift;
    logic [BW-1:0]        rx_bit;
    logic                 rx_par_ok, rx_sample, rx_stop_smp;
    logic                 rx_push, frame_set, par_set;

    // Start bit is sampled at half a period, every later bit a full period on.
    assign rx_sample   = (rx_state == RX_START) ? (rx_cnt == (rx_div >> 1)) : (rx_cnt == rx_div);
    assign rx_stop_smp = (rx_state == RX_STOP) && rx_sample;
    assign rx_push     = rx_stop_smp && rx_s2 && rx_par_ok;
    assign frame_set   = rx_stop_smp && !rx_s2;
    assign par_set     = rx_stop_smp && rx_s2 && !rx_par_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_div    <= '0;
            rx_shift  <= '0;
            rx_bit    <= '0;
            rx_par_ok <= 1'b1;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_s2) begin
                        rx_state  <= RX_START;
                        rx_cnt    <= '0;
                        rx_div    <= baud_div;
                        rx_par_ok <= 1'b1;
                    end
                end
                RX_START: begin
                    if (rx_sample) begin
                        rx_cnt <= '0;
                        if (rx_s2) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state <= RX_DATA;
                            rx_bit   <= '0;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + DIV_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_sample) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit == BW'(DATA_BITS - 1)) rx_state <= HAS_PAR ? RX_PARITY : RX_STOP;
                        else                              rx_bit   <= rx_bit + BW'(1);
                    end else begin
                        rx_cnt <= rx_cnt + DIV_W'(1);
                    end
                end
                RX_PARITY: begin
                    if (rx_sample) begin
                        rx_cnt    <= '0;
                        rx_par_ok <= (((^rx_shift) ^ rx_s2) == PAR_ODD);
                        rx_state  <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + DIV_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_sample) rx_state <= rx_s2 ? RX_IDLE : RX_WAIT_HIGH;
                    else           rx_cnt   <= rx_cnt + DIV_W'(1);
                end
                RX_WAIT_HIGH: begin
                    if (rx_s2) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS-1:0] rx_mem [DEPTH];
    logic [PW-1:0]        rx_wr, rx_rd;
    logic                 rx_full, rx_empty, rx_pop, rx_wr_en, ovr_set;

    assign rx_full      = (rx_wr[PW-1] != rx_rd[PW-1]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
    assign rx_empty     = (rx_wr == rx_rd);
    assign rx_pop       = !rx_empty && bus.rx_ready;
    assign rx_wr_en     = rx_push && (!rx_full || rx_pop);
    assign ovr_set      = rx_push && rx_full && !rx_pop;
    assign bus.rx_valid = !rx_empty;
    assign bus.rx_data  = rx_empty ? '0 : rx_mem[rx_rd[AW-1:0]];
    assign rx_level     = rx_wr - rx_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wr <= '0;
            rx_rd <= '0;
        end else begin
            if (rx_wr_en) rx_wr <= rx_wr + PW'(1);
            if (rx_pop)   rx_rd <= rx_rd + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rx_wr_en) rx_mem[rx_wr[AW-1:0]] <= rx_shift;
    end

    // Sticky error flags; a new error outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            if (frame_set)      rx_frame_err  <= 1'b1;
            else if (err_clear) rx_frame_err  <= 1'b0;
            if (par_set)        rx_parity_err <= 1'b1;
            else if (err_clear) rx_parity_err <= 1'b0;
            if (ovr_set)        rx_overrun    <= 1'b1;
            else if (err_clear) rx_overrun    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_fifo_cfg.sv
// Directed self-checking bench: dut_a uses 8E1, dut_b uses 8O2; baud_div=15.
module tb_uart_fifo_cfg;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] baud_div;
    logic        err_clear;
    logic        loop_en;
    logic        rx_a, rx_b;
    logic        tx_a, tx_b;
    logic        rx_pin_a;
    logic [4:0]  tx_level_a, rx_level_a, tx_level_b, rx_level_b;
    logic        tx_idle_a, fe_a, pe_a, ov_a;
    logic        tx_idle_b, fe_b, pe_b, ov_b;

    int total = 0;
    int bad   = 0;

    uart_fifo_cfg_if #(.DATA_BITS(8)) bus_a ();
    uart_fifo_cfg_if #(.DATA_BITS(8)) bus_b ();

    assign rx_pin_a = loop_en ? tx_a : rx_a;

    always #5 clk = ~clk;

    uart_fifo_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DIV_W(16), .DEPTH_LOG2(4)) dut_a (
        .clk(clk), .reset(reset), .baud_div(baud_div), .rx(rx_pin_a), .tx(tx_a), .bus(bus_a),
        .tx_level(tx_level_a), .rx_level(rx_level_a), .tx_idle(tx_idle_a),
        .rx_frame_err(fe_a), .rx_parity_err(pe_a), .rx_overrun(ov_a), .err_clear(err_clear)
    );

    uart_fifo_cfg #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .DIV_W(16), .DEPTH_LOG2(4)) dut_b (
        .clk(clk), .reset(reset), .baud_div(baud_div), .rx(rx_b), .tx(tx_b), .bus(bus_b),
        .tx_level(tx_level_b), .rx_level(rx_level_b), .tx_idle(tx_idle_b),
        .rx_frame_err(fe_b), .rx_parity_err(pe_b), .rx_overrun(ov_b), .err_clear(err_clear)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Even-parity 8E1 frame bit k (0 = start, 9 = parity, 10 = stop).
    function automatic logic frame_bit_even(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (k == 9) return ^d;
        return 1'b1;
    endfunction

    // Drive one 11-bit frame (16 cycles/bit) on rx_a or rx_b, then idle.
    task automatic send_frame(input bit to_b, input logic [7:0] d, input bit par_flip, input bit stop_val);
        logic [10:0] bits;
        logic        p;
        p    = (^d) ^ to_b ^ par_flip;
        bits = {stop_val, p, d, 1'b0};
        for (int k = 0; k < 11; k++) begin
            if (to_b) rx_b = bits[k];
            else      rx_a = bits[k];
            repeat (16) @(negedge clk);
        end
        rx_a = 1'b1;
        rx_b = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_a(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, 32'(bus_a.rx_valid), 32'd1);
        check(tag, 32'(bus_a.rx_data), 32'(exp));
        bus_a.rx_ready = 1'b1;
        @(negedge clk);
        bus_a.rx_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] pat55;
        logic [7:0]  lb [3];
        logic [7:0]  ov [17];
        int          lows;

        pat55 = 11'b10010101010;
        lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'hA5;
        for (int i = 0; i < 17; i++) ov[i] = 8'(i * 29 + 7);

        reset = 1'b1; baud_div = 16'd15; err_clear = 1'b0; loop_en = 1'b0;
        rx_a = 1'b1; rx_b = 1'b1;
        bus_a.tx_data = '0; bus_a.tx_valid = 1'b0; bus_a.rx_ready = 1'b0;
        bus_b.tx_data = '0; bus_b.tx_valid = 1'b0; bus_b.rx_ready = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_tx",       32'(tx_a), 32'd1);
        check("rst_tx_ready", 32'(bus_a.tx_ready), 32'd1);
        check("rst_rx_valid", 32'(bus_a.rx_valid), 32'd0);
        check("rst_tx_level", 32'(tx_level_a), 32'd0);
        check("rst_rx_level", 32'(rx_level_a), 32'd0);
        check("rst_tx_idle",  32'(tx_idle_a), 32'd1);
        check("rst_errs",     32'({fe_a, pe_a, ov_a}), 32'd0);
        check("rst_rx_data",  32'(bus_a.rx_data), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 0x55, 8E1: push at edge N, start bit from edge N+2.
        bus_a.tx_data = 8'h55; bus_a.tx_valid = 1'b1;
        @(negedge clk);
        bus_a.tx_valid = 1'b0;
        check("fmt_level", 32'(tx_level_a), 32'd1);
        check("fmt_busy",  32'(tx_idle_a), 32'd0);
        @(negedge clk);
        check("fmt_pre_start", 32'(tx_a), 32'd1);
        @(negedge clk);
        check("fmt_start_edge", 32'(tx_a), 32'd0);
        repeat (8) @(negedge clk);
        for (int k = 0; k < 11; k++) begin
            check($sformatf("fmt_bit%0d", k), 32'(tx_a), 32'(pat55[k]));
            repeat (16) @(negedge clk);
        end
        check("fmt_idle_after", 32'(tx_idle_a), 32'd1);
        check("fmt_tx_after",   32'(tx_a), 32'd1);
        repeat (10) @(negedge clk);

        // Loopback, three back-to-back frames with no idle gap.
        loop_en = 1'b1;
        bus_a.tx_valid = 1'b1; bus_a.tx_data = lb[0];
        @(negedge clk); bus_a.tx_data = lb[1];
        @(negedge clk); bus_a.tx_data = lb[2];
        @(negedge clk); bus_a.tx_valid = 1'b0;
        repeat (8) @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < 11; k++) begin
                check($sformatf("lb_f%0d_bit%0d", j, k), 32'(tx_a), 32'(frame_bit_even(lb[j], k)));
                repeat (16) @(negedge clk);
            end
        end
        repeat (4) @(negedge clk);
        check("lb_rx_level", 32'(rx_level_a), 32'd3);
        pop_a("lb_pop0", lb[0]);
        pop_a("lb_pop1", lb[1]);
        pop_a("lb_pop2", lb[2]);
        check("lb_errs", 32'({fe_a, pe_a, ov_a}), 32'd0);
        loop_en = 1'b0;
        repeat (4) @(negedge clk);

        // Overrun: 17 frames into a 16-deep FIFO with no pops.
        for (int i = 0; i < 17; i++) send_frame(1'b0, ov[i], 1'b0, 1'b1);
        check("ov_level", 32'(rx_level_a), 32'd16);
        check("ov_flag",  32'(ov_a), 32'd1);
        check("ov_other", 32'({fe_a, pe_a}), 32'd0);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("ov_cleared",     32'(ov_a), 32'd0);
        check("ov_level_kept",  32'(rx_level_a), 32'd16);
        for (int i = 0; i < 16; i++) pop_a($sformatf("ov_pop%0d", i), ov[i]);
        check("ov_drained", 32'(rx_level_a), 32'd0);

        // Framing error then a good 0x3C.
        send_frame(1'b0, 8'h11, 1'b0, 1'b0);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b1);
        check("fe_flag",   32'(fe_a), 32'd1);
        check("fe_par",    32'(pe_a), 32'd0);
        check("fe_level",  32'(rx_level_a), 32'd1);
        pop_a("fe_pop", 8'h3C);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("fe_cleared", 32'(fe_a), 32'd0);

        // 4-cycle glitch is rejected at the start-bit midpoint.
        rx_a = 1'b0;
        repeat (4) @(negedge clk);
        rx_a = 1'b1;
        repeat (40) @(negedge clk);
        check("gl_level", 32'(rx_level_a), 32'd0);
        check("gl_errs",  32'({fe_a, pe_a, ov_a}), 32'd0);

        // Odd parity: wrong parity discarded, then a correct frame accepted.
        send_frame(1'b1, 8'h5A, 1'b1, 1'b1);
        check("pe_flag",  32'(pe_b), 32'd1);
        check("pe_level", 32'(rx_level_b), 32'd0);
        send_frame(1'b1, 8'h5A, 1'b0, 1'b1);
        check("pe_good_level", 32'(rx_level_b), 32'd1);
        check("pe_good_data",  32'(bus_b.rx_data), 32'h5A);
        check("pe_fe_b",       32'(fe_b), 32'd0);

        // Fill the TX FIFO with zeros, then reset mid DATA.
        bus_a.tx_data = 8'h00; bus_a.tx_valid = 1'b1;
        repeat (17) @(negedge clk);
        bus_a.tx_valid = 1'b0;
        check("full_level", 32'(tx_level_a), 32'd16);
        check("full_ready", 32'(bus_a.tx_ready), 32'd0);
        repeat (40) @(negedge clk);
        check("pre_reset_tx", 32'(tx_a), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_tx",    32'(tx_a), 32'd1);
        check("mrst_level", 32'(tx_level_a), 32'd0);
        check("mrst_idle",  32'(tx_idle_a), 32'd1);
        lows = 0;
        repeat (400) begin
            @(negedge clk);
            if (!tx_a) lows++;
        end
        check("mrst_no_frame", 32'(lows), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
